// File: rtl/sprite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sprite_pkg                                           |
// | Description : Shared types and constants for the sprite motion     |
// |               scheduler: coordinate width, signed velocity type,   |
// |               scheduler state encoding and velocity saturation.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package sprite_pkg;

  localparam int CORDW = 10;

  typedef logic signed [3:0] vel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Most negative velocity that may be stored. Keeping -8 out of the
  // register file means a bounce (negation) can never overflow.
  localparam vel_t VEL_MIN = -4'sd7;

  function automatic vel_t sat_vel(input vel_t v);
    return (v < VEL_MIN) ? VEL_MIN : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_axis_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sprite_axis_step                                     |
// | Description : Combinational single-axis move with edge bounce.     |
// |               Adds the velocity to the position; clamps to 0 or    |
// |               limit and reverses velocity when the move overshoots.|
// | Ports       : pos     - current position                           |
// |               vel     - current signed velocity                    |
// |               limit   - largest legal position                     |
// |               pos_nxt - updated position                           |
// |               vel_nxt - updated velocity                           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module sprite_axis_step
  import sprite_pkg::*;
#(
  parameter int CORDW = sprite_pkg::CORDW
) (
  input  logic [CORDW-1:0] pos,
  input  vel_t             vel,
  input  logic [CORDW-1:0] limit,
  output logic [CORDW-1:0] pos_nxt,
  output vel_t             vel_nxt
);

  // One extra bit so a step below zero is visible as a negative value.
  logic signed [CORDW:0] w_sum;

  always_comb begin
    w_sum   = $signed({1'b0, pos}) + $signed({{(CORDW-3){vel[3]}}, vel});
    pos_nxt = w_sum[CORDW-1:0];
    vel_nxt = vel;
    if (w_sum[CORDW]) begin
      pos_nxt = '0;
      vel_nxt = -vel;
    end else if (w_sum > $signed({1'b0, limit})) begin
      pos_nxt = limit;
      vel_nxt = -vel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sprite_motion_ctrl                                   |
// | Description : Per-frame motion scheduler for N_SQ bouncing squares.|
// |               On frame_start it sweeps the squares one per pixel   |
// |               strobe; between frames it accepts position/velocity  |
// |               commands over a valid/ready handshake.               |
// | Ports       : clk, rst_n           - clock, async active-low reset |
// |               stb_pix              - pixel strobe (state enable)   |
// |               frame_start          - start-of-frame pulse          |
// |               pause, step          - freeze / single-step control  |
// |               cmd_valid/cmd_ready  - command handshake             |
// |               cmd_id,cmd_x,cmd_y   - target square and position    |
// |               cmd_dx, cmd_dy       - signed velocities             |
// |               qx, qy               - packed square positions       |
// |               busy                 - sweep in progress             |
// |               upd_done             - sweep-complete strobe         |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int N_SQ   = 4,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int Q_SIZE = 32,
  parameter int CORDW  = sprite_pkg::CORDW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stb_pix,
  input  logic                  frame_start,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_id,
  input  logic [CORDW-1:0]      cmd_x,
  input  logic [CORDW-1:0]      cmd_y,
  input  vel_t                  cmd_dx,
  input  vel_t                  cmd_dy,
  output logic [N_SQ*CORDW-1:0] qx,
  output logic [N_SQ*CORDW-1:0] qy,
  output logic                  busy,
  output logic                  upd_done
);

  localparam int               c_IDXW  = (N_SQ > 1) ? $clog2(N_SQ) : 1;
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(N_SQ - 1);
  localparam logic [CORDW-1:0] c_LIM_X = CORDW'(H_RES - Q_SIZE);
  localparam logic [CORDW-1:0] c_LIM_Y = CORDW'(V_RES - Q_SIZE);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_IDXW-1:0]   r_idx;
  logic                r_step_pend;

  logic                w_start;
  logic                w_upd;
  logic                w_cmd_xfer;
  logic [CORDW-1:0]    w_cmd_x;
  logic [CORDW-1:0]    w_cmd_y;
  vel_t                w_cmd_dx;
  vel_t                w_cmd_dy;

  logic [N_SQ*4-1:0]   w_dx_all;
  logic [N_SQ*4-1:0]   w_dy_all;
  logic [CORDW-1:0]    w_cur_x;
  logic [CORDW-1:0]    w_cur_y;
  vel_t                w_cur_dx;
  vel_t                w_cur_dy;
  logic [CORDW-1:0]    w_nx;
  logic [CORDW-1:0]    w_ny;
  vel_t                w_ndx;
  vel_t                w_ndy;

  // Frame start wins over a command arriving on the same strobe.
  assign cmd_ready  = (r_state == IDLE) && !frame_start;
  assign w_cmd_xfer = stb_pix && cmd_valid && cmd_ready;
  assign w_start    = stb_pix && (r_state == IDLE) && frame_start &&
                      (!pause || r_step_pend);
  assign w_upd      = stb_pix && (r_state == UPDATE);

  assign w_cmd_x  = (cmd_x > c_LIM_X) ? c_LIM_X : cmd_x;
  assign w_cmd_y  = (cmd_y > c_LIM_Y) ? c_LIM_Y : cmd_y;
  assign w_cmd_dx = sat_vel(cmd_dx);
  assign w_cmd_dy = sat_vel(cmd_dy);

  // Current square selected by the sweep index.
  assign w_cur_x  = qx[r_idx*CORDW +: CORDW];
  assign w_cur_y  = qy[r_idx*CORDW +: CORDW];
  assign w_cur_dx = w_dx_all[r_idx*4 +: 4];
  assign w_cur_dy = w_dy_all[r_idx*4 +: 4];

  sprite_axis_step #(.CORDW(CORDW)) u_axis_x (
    .pos     (w_cur_x),
    .vel     (w_cur_dx),
    .limit   (c_LIM_X),
    .pos_nxt (w_nx),
    .vel_nxt (w_ndx)
  );

  sprite_axis_step #(.CORDW(CORDW)) u_axis_y (
    .pos     (w_cur_y),
    .vel     (w_cur_dy),
    .limit   (c_LIM_Y),
    .pos_nxt (w_ny),
    .vel_nxt (w_ndy)
  );

  // State register, sweep index and pending single-step request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_step_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_idx <= '0;
      end else if (w_upd) begin
        r_idx <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
      end
      if (w_start) begin
        r_step_pend <= 1'b0;
      end else if (stb_pix && step && pause) begin
        r_step_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    upd_done    = (r_state == DONE);
    if (stb_pix) begin
      unique case (r_state)
        IDLE:    if (w_start) w_state_nxt = UPDATE;
        UPDATE:  if (r_idx == c_LAST) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Per-square position/velocity registers. Sweep and command can never
  // hit the same square on one strobe because commands are only taken
  // in IDLE.
  for (genvar i = 0; i < N_SQ; i++) begin : g_sq
    logic [CORDW-1:0] r_x;
    logic [CORDW-1:0] r_y;
    vel_t             r_dx;
    vel_t             r_dy;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x  <= '0;
        r_y  <= CORDW'(i * Q_SIZE);
        r_dx <= 4'sd1;
        r_dy <= 4'sd1;
      end else if (w_upd && (r_idx == c_IDXW'(i))) begin
        r_x  <= w_nx;
        r_y  <= w_ny;
        r_dx <= w_ndx;
        r_dy <= w_ndy;
      end else if (w_cmd_xfer && (cmd_id == 3'(i))) begin
        r_x  <= w_cmd_x;
        r_y  <= w_cmd_y;
        r_dx <= w_cmd_dx;
        r_dy <= w_cmd_dy;
      end
    end

    assign qx[i*CORDW +: CORDW] = r_x;
    assign qy[i*CORDW +: CORDW] = r_y;
    assign w_dx_all[i*4 +: 4]   = r_dx;
    assign w_dy_all[i*4 +: 4]   = r_dy;
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_sprite_motion_ctrl                                |
// | Description : Directed self-checking bench for sprite_motion_ctrl. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_sprite_motion_ctrl;

  localparam int c_N  = 4;
  localparam int c_CW = 10;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stb_pix;
  logic                  frame_start;
  logic                  pause;
  logic                  step;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_id;
  logic [c_CW-1:0]       cmd_x;
  logic [c_CW-1:0]       cmd_y;
  logic signed [3:0]     cmd_dx;
  logic signed [3:0]     cmd_dy;
  logic [c_N*c_CW-1:0]   qx;
  logic [c_N*c_CW-1:0]   qy;
  logic                  busy;
  logic                  upd_done;

  int checks   = 0;
  int failures = 0;
  int nd;
  int nb;
  int tot;

  sprite_motion_ctrl #(
    .N_SQ(c_N), .H_RES(640), .V_RES(480), .Q_SIZE(32), .CORDW(c_CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stb_pix(stb_pix), .frame_start(frame_start),
    .pause(pause), .step(step), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_dx(cmd_dx),
    .cmd_dy(cmd_dy), .qx(qx), .qy(qy), .busy(busy), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gx(input int i);
    return 32'(qx[i*c_CW +: c_CW]);
  endfunction

  function automatic logic [31:0] gy(input int i);
    return 32'(qy[i*c_CW +: c_CW]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobe value; outputs sampled 1 ns later.
  task automatic tick(input logic s);
    stb_pix = s;
    @(posedge clk);
    #1;
    stb_pix = 1'b0;
  endtask

  // Pulse frame_start and run strobes until the sweep ends (bounded).
  task automatic frame(output int n_done, output int n_busy);
    n_done = 0;
    n_busy = 0;
    frame_start = 1'b1;
    tick(1'b1);
    frame_start = 1'b0;
    if (busy === 1'b1) n_busy++;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b1) break;
      tick(1'b1);
      if (upd_done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    chk("sweep_ends", 32'(busy), 32'd0);
  endtask

  task automatic cmd(input int id, input int x, input int y, input int dx, input int dy);
    cmd_id    = 3'(id);
    cmd_x     = c_CW'(x);
    cmd_y     = c_CW'(y);
    cmd_dx    = 4'(dx);
    cmd_dy    = 4'(dy);
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick(1'b1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stb_pix = 1'b0; frame_start = 1'b0; pause = 1'b0; step = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; cmd_x = '0; cmd_y = '0; cmd_dx = '0; cmd_dy = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    for (int i = 0; i < c_N; i++) begin
      chk("rst_qx", gx(i), 32'd0);
      chk("rst_qy", gy(i), 32'(i * 32));
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(upd_done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // frame_start without strobe must not start a sweep
    frame_start = 1'b1;
    tick(1'b0);
    chk("no_stb_busy", 32'(busy), 32'd0);

    // First frame, stepped by hand
    tick(1'b1);
    frame_start = 1'b0;
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_ready", 32'(cmd_ready), 32'd0);
    tick(1'b0);
    chk("f1_gate_x0", gx(0), 32'd0);
    tick(1'b1);
    chk("f1_x0", gx(0), 32'd1);
    chk("f1_y0", gy(0), 32'd1);
    chk("f1_x1_pending", gx(1), 32'd0);
    frame_start = 1'b1;            // arrives mid-sweep: dropped
    tick(1'b1);
    frame_start = 1'b0;
    tick(1'b1);
    chk("f1_x2", gx(2), 32'd1);
    chk("f1_y2", gy(2), 32'd65);
    chk("f1_done_early", 32'(upd_done), 32'd0);
    tick(1'b1);
    chk("f1_done", 32'(upd_done), 32'd1);
    chk("f1_busy_done", 32'(busy), 32'd1);
    chk("f1_y3", gy(3), 32'd97);
    tick(1'b1);
    chk("f1_done_clr", 32'(upd_done), 32'd0);
    chk("f1_idle", 32'(busy), 32'd0);
    tick(1'b1);
    tick(1'b1);
    chk("fs_not_queued", 32'(busy), 32'd0);

    // Right-edge bounce
    cmd(1, 606, 10, 3, -2);
    chk("c1_x", gx(1), 32'd606);
    chk("c1_y", gy(1), 32'd10);
    frame(nd, nb);
    chk("c1_nd", 32'(nd), 32'd1);
    chk("c1_nb", 32'(nb), 32'd5);
    chk("c1_bx", gx(1), 32'd608);
    chk("c1_by", gy(1), 32'd8);
    frame(nd, nb);
    chk("c1_bx2", gx(1), 32'd605);
    chk("c1_by2", gy(1), 32'd6);

    // Velocity -8 saturation, left bounce, exact-zero landing
    cmd(0, 1, 1, -8, -1);
    chk("c0_x", gx(0), 32'd1);
    frame(nd, nb);
    chk("c0_f1_x", gx(0), 32'd0);
    chk("c0_f1_y", gy(0), 32'd0);
    frame(nd, nb);
    chk("c0_f2_x", gx(0), 32'd7);
    chk("c0_f2_y", gy(0), 32'd0);
    frame(nd, nb);
    chk("c0_f3_x", gx(0), 32'd14);
    chk("c0_f3_y", gy(0), 32'd1);

    // Position clamp and out-of-range id
    cmd(3, 1000, 700, 1, 1);
    chk("clamp_x", gx(3), 32'd608);
    chk("clamp_y", gy(3), 32'd448);
    cmd(5, 0, 0, 0, 0);
    chk("bad_id_x3", gx(3), 32'd608);
    chk("bad_id_x0", gx(0), 32'd14);
    chk("bad_id_y0", gy(0), 32'd1);

    // step while running is ignored; pause freezes motion
    step = 1'b1;
    tick(1'b1);
    step = 1'b0;
    pause = 1'b1;
    tot = 0;
    for (int f = 0; f < 3; f++) begin
      frame(nd, nb);
      tot += nd;
    end
    chk("pause_nd", 32'(tot), 32'd0);
    chk("pause_x0", gx(0), 32'd14);
    step = 1'b1;
    tick(1'b1);
    step = 1'b0;
    frame(nd, nb);
    chk("step_nd", 32'(nd), 32'd1);
    chk("step_x0", gx(0), 32'd21);
    chk("step_y0", gy(0), 32'd2);
    frame(nd, nb);
    chk("step_once_nd", 32'(nd), 32'd0);
    chk("step_once_x0", gx(0), 32'd21);
    pause = 1'b0;

    // frame_start beats a concurrent command
    cmd_id = 3'd0; cmd_x = 10'd100; cmd_y = 10'd100; cmd_dx = 4'sd1; cmd_dy = 4'sd1;
    cmd_valid = 1'b1;
    frame_start = 1'b1;
    chk("coll_ready", 32'(cmd_ready), 32'd0);
    tick(1'b1);
    frame_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1);
      chk("coll_ready_busy", 32'(cmd_ready), 32'd0);
    end
    tick(1'b1);
    chk("coll_swept_x0", gx(0), 32'd28);
    chk("coll_swept_y0", gy(0), 32'd3);
    chk("coll_ready_idle", 32'(cmd_ready), 32'd1);
    tick(1'b1);
    cmd_valid = 1'b0;
    chk("coll_cmd_x0", gx(0), 32'd100);
    chk("coll_cmd_y0", gy(0), 32'd100);

    // Asynchronous reset in the middle of a sweep (idx=2)
    frame_start = 1'b1;
    tick(1'b1);
    frame_start = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("mid_x0", gx(0), 32'd101);
    rst_n = 1'b0;
    #1;
    chk("arst_x0", gx(0), 32'd0);
    chk("arst_y0", gy(0), 32'd0);
    chk("arst_y2", gy(2), 32'd64);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(upd_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_done_hold", 32'(upd_done), 32'd0);
    rst_n = 1'b1;
    frame(nd, nb);
    chk("post_rst_nd", 32'(nd), 32'd1);
    chk("post_rst_nb", 32'(nb), 32'd5);
    chk("post_rst_x0", gx(0), 32'd1);
    chk("post_rst_y2", gy(2), 32'd65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
